// File: rtl/ecc_sram_corrector_pkg.sv
// Shared constants and types for the page ECC write-back corrector.
// Segment geometry, SRAM base addresses, decoder codes and FSM states.
package ecc_sram_corrector_pkg;

   localparam int SEG_LEN = 172;
   localparam int NSEG    = 3;
   localparam int FLAG_LO = 160;
   localparam int FLAG_HI = 163;
   localparam int TAIL_LO = 164;

   localparam logic [8:0] SEG0_BASE = 9'd0;
   localparam logic [8:0] SEG1_BASE = 9'd172;
   localparam logic [8:0] SEG2_BASE = 9'd344;
   localparam logic [8:0] TAIL_BASE = 9'd504;

   typedef enum logic [1:0] {
      CODE_NONE = 2'b00,
      CODE_ONE  = 2'b01,
      CODE_TWO  = 2'b10,
      CODE_UNC  = 2'b11
   } code_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RD0,
      ST_WT0,
      ST_WR0,
      ST_RD1,
      ST_WT1,
      ST_WR1,
      ST_FIN
   } state_e;

   typedef struct packed {
      logic [1:0] seg;
      code_e      code;
      logic [7:0] loc0;
      logic [7:0] val0;
      logic [7:0] loc1;
      logic [7:0] val1;
   } pend_t;

endpackage

// File: rtl/ecc_sram_corrector_loc_map.sv
// Maps (segment, symbol location) to a page-buffer address.
// Ports: seg, loc in; valid (byte is writable), is_flag, adrs out.
module ecc_sram_corrector_loc_map
   import ecc_sram_corrector_pkg::*;
(
   input  logic [1:0] seg,
   input  logic [7:0] loc,
   output logic       valid,
   output logic       is_flag,
   output logic [8:0] adrs
);

   logic [8:0] loc9;

   assign loc9 = {1'b0, loc};

   // Segment 2 holds the flag bytes in the middle; the
   // data after them lives in the tail of the buffer.
   always_comb begin
      valid   = 1'b0;
      is_flag = 1'b0;
      adrs    = '0;
      unique case (seg)
         2'd0: begin
            if (loc9 < 9'(SEG_LEN)) begin
               valid = 1'b1;
               adrs  = SEG0_BASE + loc9;
            end
         end
         2'd1: begin
            if (loc9 < 9'(SEG_LEN)) begin
               valid = 1'b1;
               adrs  = SEG1_BASE + loc9;
            end
         end
         2'd2: begin
            if (loc9 < 9'(FLAG_LO)) begin
               valid = 1'b1;
               adrs  = SEG2_BASE + loc9;
            end else if (loc9 <= 9'(FLAG_HI)) begin
               is_flag = 1'b1;
            end else if (loc9 < 9'(SEG_LEN)) begin
               valid = 1'b1;
               adrs  = TAIL_BASE + loc9 - 9'(TAIL_LO);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ecc_sram_corrector.sv
// RS result write-back: XOR-corrects bad bytes in the 512x8 page SRAM.
// Ports: start/RSdone/RSresults in; SRAM req/gnt bus; corrDone, status out.
module ecc_sram_corrector
   import ecc_sram_corrector_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        RSdone,
   input  logic [33:0] RSresults,
   input  logic        sramGnt,
   input  logic [7:0]  sramDo,
   output logic        sramReq,
   output logic        sramEnable,
   output logic        sramWE,
   output logic [8:0]  sramAdrs,
   output logic [7:0]  sramDi,
   output logic        corrDone,
   output logic [7:0]  status
);

   state_e     state;
   state_e     nstate;
   pend_t      pend;
   logic       pend_full;
   logic [1:0] seg_cnt;
   logic [7:0] rdata_q;
   logic       done_q;
   logic       flag_q;
   logic       ovf_q;
   logic       fix_q;
   logic [2:0] unc_q;

   logic       m0_valid;
   logic       m0_flag;
   logic [8:0] m0_adrs;
   logic       m1_valid;
   logic       m1_flag;
   logic [8:0] m1_adrs;

   logic       has0;
   logic       has1;
   logic       same;
   logic       need0;
   logic       need1;
   logic       flag_hit;
   logic [7:0] wval0;
   logic       wr_fire;
   logic       busy;

   ecc_sram_corrector_loc_map u_map0 (
      .seg     (pend.seg),
      .loc     (pend.loc0),
      .valid   (m0_valid),
      .is_flag (m0_flag),
      .adrs    (m0_adrs)
   );

   ecc_sram_corrector_loc_map u_map1 (
      .seg     (pend.seg),
      .loc     (pend.loc1),
      .valid   (m1_valid),
      .is_flag (m1_flag),
      .adrs    (m1_adrs)
   );

   assign has0 = (pend.code == CODE_ONE) ||
                 (pend.code == CODE_TWO);
   assign has1 = (pend.code == CODE_TWO);

   // Two errors on one symbol collapse into a
   // single write of the combined pattern.
   assign same  = has1 && (pend.loc0 == pend.loc1);
   assign need0 = has0 && m0_valid;
   assign need1 = has1 && !same && m1_valid;
   assign wval0 = same ? (pend.val0 ^ pend.val1)
                       : pend.val0;

   assign flag_hit = (has0 && m0_flag) ||
                     (has1 && m1_flag);

   assign busy   = (state != ST_IDLE) || pend_full;
   assign status = {fix_q, ovf_q, flag_q,
                    unc_q, done_q, busy};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate     = state;
      sramReq    = 1'b0;
      sramEnable = 1'b1;
      sramWE     = 1'b0;
      sramAdrs   = '0;
      sramDi     = '0;
      wr_fire    = 1'b0;
      corrDone   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (pend_full) nstate = ST_LOAD;
         end
         ST_LOAD: begin
            if (need0)      nstate = ST_RD0;
            else if (need1) nstate = ST_RD1;
            else            nstate = ST_FIN;
         end
         ST_RD0: begin
            sramReq = 1'b1;
            if (sramGnt) begin
               sramEnable = 1'b0;
               sramAdrs   = m0_adrs;
               nstate     = ST_WT0;
            end
         end
         ST_WT0: begin
            sramReq = 1'b1;
            nstate  = ST_WR0;
         end
         ST_WR0: begin
            sramReq = 1'b1;
            if (sramGnt) begin
               sramEnable = 1'b0;
               sramWE     = 1'b1;
               sramAdrs   = m0_adrs;
               sramDi     = rdata_q ^ wval0;
               wr_fire    = 1'b1;
               nstate     = need1 ? ST_RD1 : ST_FIN;
            end
         end
         ST_RD1: begin
            sramReq = 1'b1;
            if (sramGnt) begin
               sramEnable = 1'b0;
               sramAdrs   = m1_adrs;
               nstate     = ST_WT1;
            end
         end
         ST_WT1: begin
            sramReq = 1'b1;
            nstate  = ST_WR1;
         end
         ST_WR1: begin
            sramReq = 1'b1;
            if (sramGnt) begin
               sramEnable = 1'b0;
               sramWE     = 1'b1;
               sramAdrs   = m1_adrs;
               sramDi     = rdata_q ^ pend.val1;
               wr_fire    = 1'b1;
               nstate     = ST_FIN;
            end
         end
         ST_FIN: begin
            corrDone = (pend.seg == 2'd2);
            nstate   = ST_IDLE;
         end
         default: nstate = ST_IDLE;
      endcase
      // Abort still lets this cycle's bus access finish.
      if (start) nstate = ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend      <= '0;
         pend_full <= 1'b0;
         seg_cnt   <= '0;
         rdata_q   <= '0;
         done_q    <= 1'b0;
         flag_q    <= 1'b0;
         ovf_q     <= 1'b0;
         fix_q     <= 1'b0;
         unc_q     <= '0;
      end else if (start) begin
         pend_full <= 1'b0;
         seg_cnt   <= '0;
         done_q    <= 1'b0;
         flag_q    <= 1'b0;
         ovf_q     <= 1'b0;
         fix_q     <= 1'b0;
         unc_q     <= '0;
      end else begin
         if (state == ST_FIN) pend_full <= 1'b0;
         if (RSdone) begin
            if (pend_full || seg_cnt == 2'(NSEG)) begin
               ovf_q <= 1'b1;
            end else begin
               pend      <= pend_t'({seg_cnt, RSresults});
               pend_full <= 1'b1;
               seg_cnt   <= seg_cnt + 2'd1;
            end
         end
         if (state == ST_WT0 || state == ST_WT1)
            rdata_q <= sramDo;
         if (state == ST_LOAD) begin
            if (pend.code == CODE_UNC)
               unc_q <= unc_q | (3'b001 << pend.seg);
            if (flag_hit) flag_q <= 1'b1;
         end
         if (wr_fire) fix_q <= 1'b1;
         if (corrDone) done_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ecc_sram_corrector.sv
// Self-checking bench for ecc_sram_corrector with an SRAM model.
// Table vectors, corner-case sequences, and randomized pages.
module tb_ecc_sram_corrector;

   logic        clk;
   logic        reset;
   logic        start;
   logic        RSdone;
   logic [33:0] RSresults;
   logic        sramGnt;
   logic [7:0]  sramDo = 8'h00;
   logic        sramReq;
   logic        sramEnable;
   logic        sramWE;
   logic [8:0]  sramAdrs;
   logic [7:0]  sramDi;
   logic        corrDone;
   logic [7:0]  status;

   ecc_sram_corrector dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .RSdone     (RSdone),
      .RSresults  (RSresults),
      .sramGnt    (sramGnt),
      .sramDo     (sramDo),
      .sramReq    (sramReq),
      .sramEnable (sramEnable),
      .sramWE     (sramWE),
      .sramAdrs   (sramAdrs),
      .sramDi     (sramDi),
      .corrDone   (corrDone),
      .status     (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [512];
   logic [7:0] exp_mem [512];
   int         wr_cnt = 0;
   int         cd_cnt = 0;
   int         viol = 0;
   logic       pl_we = 1'b0;
   logic [8:0] pl_adr = '0;
   logic [7:0] pl_dat = '0;
   logic       gnt_rand = 1'b0;
   logic       gnt_fix = 1'b0;

   always @(posedge clk) begin
      if (pl_we) begin
         mem[pl_adr] <= pl_dat;
      end else if (!sramEnable) begin
         if (sramWE) begin
            mem[sramAdrs] <= sramDi;
            wr_cnt <= wr_cnt + 1;
         end else begin
            sramDo <= mem[sramAdrs];
         end
      end
      if (!sramEnable && !(sramReq && sramGnt))
         viol <= viol + 1;
      if (corrDone) cd_cnt <= cd_cnt + 1;
   end

   always @(negedge clk)
      sramGnt = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_fix;

   // Reference model: page-level effect of each accepted result.
   int         pg_seg;
   logic [2:0] e_unc;
   logic       e_flag, e_ovf, e_fix, e_done;

   function automatic void page_clear();
      pg_seg = 0;
      e_unc  = '0;
      e_flag = 1'b0;
      e_ovf  = 1'b0;
      e_fix  = 1'b0;
      e_done = 1'b0;
   endfunction

   function automatic void fix_byte(int s, int l, logic [7:0] v);
      int a;
      a = -1;
      if (s == 2 && l >= 160 && l <= 163) begin
         e_flag = 1'b1;
         return;
      end
      if (s < 2 && l < 172)                  a = 172 * s + l;
      else if (s == 2 && l < 160)            a = 344 + l;
      else if (s == 2 && l >= 164 && l < 172) a = 504 + (l - 164);
      if (a >= 0) begin
         exp_mem[a] = exp_mem[a] ^ v;
         e_fix = 1'b1;
      end
   endfunction

   function automatic void accept(logic [33:0] r);
      int l0, l1;
      l0 = int'(r[31:24]);
      l1 = int'(r[15:8]);
      if (pg_seg >= 3) begin
         e_ovf = 1'b1;
         return;
      end
      case (r[33:32])
         2'b01: fix_byte(pg_seg, l0, r[23:16]);
         2'b10: begin
            if (l0 == l1) fix_byte(pg_seg, l0, r[23:16] ^ r[7:0]);
            else begin
               fix_byte(pg_seg, l0, r[23:16]);
               fix_byte(pg_seg, l1, r[7:0]);
            end
         end
         2'b11: e_unc[pg_seg] = 1'b1;
         default: ;
      endcase
      if (pg_seg == 2) e_done = 1'b1;
      pg_seg++;
   endfunction

   function automatic logic [7:0] exp_stat();
      return {e_fix, e_ovf, e_flag, e_unc, e_done, 1'b0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic preload(input int a, input logic [7:0] d);
      @(negedge clk);
      pl_we  = 1'b1;
      pl_adr = 9'(a);
      pl_dat = d;
      exp_mem[a] = d;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic send_rs(input logic [33:0] r);
      @(negedge clk);
      RSdone    = 1'b1;
      RSresults = r;
      @(negedge clk);
      RSdone = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (status[0] && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(nm, {31'b0, status[0]}, 32'd0);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      page_clear();
   endtask

   function automatic logic [33:0] mk(logic [1:0] c, logic [7:0] l0,
                                      logic [7:0] v0, logic [7:0] l1,
                                      logic [7:0] v1);
      return {c, l0, v0, l1, v1};
   endfunction

   typedef struct {
      int          seg;
      logic [33:0] res;
      int          adrs;
      logic [7:0]  init;
      logic [7:0]  exp_byte;
      int          exp_wr;
      logic [7:0]  exp_st;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int wr0, cd0, bad, n, found;
      logic [33:0] r;
      logic [7:0] l0, l1;

      reset     = 1'b0;
      start     = 1'b0;
      RSdone    = 1'b0;
      RSresults = '0;
      page_clear();
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {sramReq, sramEnable, sramWE, corrDone,
           sramAdrs, sramDi, status},
          {1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0, 8'd0});
      reset = 1'b1;

      for (int i = 0; i < 512; i++)
         preload(i, 8'($urandom));

      tbl[0]  = '{0, mk(2'b01, 8'd5,   8'h3C, 8'd0,   8'h00), 5,   8'hA5, 8'h99, 1, 8'h80};
      tbl[1]  = '{2, mk(2'b10, 8'd161, 8'h55, 8'd170, 8'h01), 510, 8'h40, 8'h41, 1, 8'hA2};
      tbl[2]  = '{1, mk(2'b10, 8'd20,  8'h0F, 8'd20,  8'hF0), 192, 8'h12, 8'hED, 1, 8'h80};
      tbl[3]  = '{1, mk(2'b11, 8'd28,  8'h11, 8'd0,   8'h00), 200, 8'h77, 8'h77, 0, 8'h08};
      tbl[4]  = '{2, mk(2'b01, 8'd163, 8'hAA, 8'd0,   8'h00), 507, 8'h33, 8'h33, 0, 8'h22};
      tbl[5]  = '{2, mk(2'b01, 8'd171, 8'h80, 8'd0,   8'h00), 511, 8'h01, 8'h81, 1, 8'h82};
      tbl[6]  = '{0, mk(2'b01, 8'd173, 8'hFF, 8'd0,   8'h00), 173, 8'h5A, 8'h5A, 0, 8'h00};
      tbl[7]  = '{1, mk(2'b01, 8'd171, 8'hFF, 8'd0,   8'h00), 343, 8'h00, 8'hFF, 1, 8'h80};
      tbl[8]  = '{2, mk(2'b01, 8'd159, 8'h0F, 8'd0,   8'h00), 503, 8'hF0, 8'hFF, 1, 8'h82};
      tbl[9]  = '{0, mk(2'b10, 8'd0,   8'h01, 8'd172, 8'h02), 0,   8'h10, 8'h11, 1, 8'h80};
      tbl[10] = '{1, mk(2'b10, 8'd200, 8'h44, 8'd3,   8'h08), 175, 8'h00, 8'h08, 1, 8'h80};
      tbl[11] = '{0, mk(2'b00, 8'd9,   8'hFF, 8'd0,   8'h00), 9,   8'h21, 8'h21, 0, 8'h00};

      gnt_fix = 1'b1;
      for (int i = 0; i < 12; i++) begin
         do_start();
         preload(tbl[i].adrs, tbl[i].init);
         for (int s = 0; s < tbl[i].seg; s++) begin
            send_rs('0);
            accept('0);
            wait_idle("vec_pre_idle");
         end
         wr0 = wr_cnt;
         cd0 = cd_cnt;
         send_rs(tbl[i].res);
         accept(tbl[i].res);
         wait_idle("vec_idle");
         chk($sformatf("vec%0d_byte", i),
             32'(mem[tbl[i].adrs]), 32'(tbl[i].exp_byte));
         chk($sformatf("vec%0d_writes", i),
             wr_cnt - wr0, tbl[i].exp_wr);
         chk($sformatf("vec%0d_status", i),
             32'(status), 32'(tbl[i].exp_st));
         chk($sformatf("vec%0d_corrdone", i),
             cd_cnt - cd0, (tbl[i].seg == 2) ? 1 : 0);
      end

      // Three segments: clean, uncorrectable, clean.
      do_start();
      wr0 = wr_cnt;
      cd0 = cd_cnt;
      send_rs(mk(2'b00, 8'd1, 8'h1, 8'd2, 8'h2));
      wait_idle("seq3_idle0");
      send_rs(mk(2'b11, 8'd1, 8'h1, 8'd2, 8'h2));
      wait_idle("seq3_idle1");
      send_rs(mk(2'b00, 8'd1, 8'h1, 8'd2, 8'h2));
      wait_idle("seq3_idle2");
      chk("seq3_status", 32'(status), 32'h0A);
      chk("seq3_writes", wr_cnt - wr0, 0);
      chk("seq3_corrdone", cd_cnt - cd0, 1);

      // Second result while the first is still pending.
      gnt_fix = 1'b0;
      do_start();
      r = mk(2'b01, 8'd5, 8'h01, 8'd0, 8'h00);
      send_rs(r);
      accept(r);
      repeat (3) @(negedge clk);
      send_rs(mk(2'b01, 8'd6, 8'h02, 8'd0, 8'h00));
      e_ovf = 1'b1;
      chk("ovf_flag", {31'b0, status[6]}, 32'd1);
      chk("ovf_busy", {31'b0, status[0]}, 32'd1);
      gnt_fix = 1'b1;
      wait_idle("ovf_idle");
      chk("ovf_byte5", 32'(mem[5]), 32'(exp_mem[5]));
      chk("ovf_byte6", 32'(mem[6]), 32'(exp_mem[6]));
      chk("ovf_status", 32'(status), 32'(exp_stat()));

      // Abort in the wait cycle after the seg1 read.
      do_start();
      send_rs('0);
      accept('0);
      wait_idle("abort_idle0");
      wr0 = wr_cnt;
      send_rs(mk(2'b01, 8'd10, 8'h11, 8'd0, 8'h00));
      found = 0;
      n = 0;
      while (!found && n < 20) begin
         if (!sramEnable && !sramWE) found = 1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      chk("abort_read_seen", found, 1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      page_clear();
      chk("abort_status", 32'(status), 32'h00);
      chk("abort_req", {31'b0, sramReq}, 32'd0);
      @(negedge clk);
      chk("abort_writes", wr_cnt - wr0, 0);
      r = mk(2'b01, 8'd10, 8'h22, 8'd0, 8'h00);
      send_rs(r);
      accept(r);
      wait_idle("abort_idle1");
      chk("abort_seg0_byte", 32'(mem[10]), 32'(exp_mem[10]));
      chk("abort_seg1_byte", 32'(mem[182]), 32'(exp_mem[182]));

      // start and RSdone together: result is discarded silently.
      @(negedge clk);
      start     = 1'b1;
      RSdone    = 1'b1;
      RSresults = mk(2'b01, 8'd1, 8'hFF, 8'd0, 8'h00);
      @(negedge clk);
      start  = 1'b0;
      RSdone = 1'b0;
      page_clear();
      @(negedge clk);
      chk("startrs_status", 32'(status), 32'h00);
      r = mk(2'b01, 8'd2, 8'h04, 8'd0, 8'h00);
      send_rs(r);
      accept(r);
      wait_idle("startrs_idle");
      chk("startrs_byte1", 32'(mem[1]), 32'(exp_mem[1]));
      chk("startrs_byte2", 32'(mem[2]), 32'(exp_mem[2]));
      chk("startrs_final", 32'(status), 32'(exp_stat()));

      // Randomized pages with a jittery grant.
      gnt_rand = 1'b1;
      for (int p = 0; p < 40; p++) begin
         do_start();
         cd0 = cd_cnt;
         n = int'($urandom_range(1, 4));
         for (int k = 0; k < n; k++) begin
            l0 = 8'($urandom_range(0, 190));
            l1 = ($urandom_range(0, 3) == 0) ? l0
                 : 8'($urandom_range(0, 190));
            r = mk(2'($urandom_range(0, 3)), l0, 8'($urandom),
                   l1, 8'($urandom));
            send_rs(r);
            accept(r);
            wait_idle("rnd_idle");
         end
         chk($sformatf("rnd%0d_status", p),
             32'(status), 32'(exp_stat()));
         chk($sformatf("rnd%0d_corrdone", p),
             cd_cnt - cd0, e_done ? 1 : 0);
      end
      gnt_rand = 1'b0;
      @(negedge clk);

      bad = 0;
      for (int i = 0; i < 512; i++)
         if (mem[i] !== exp_mem[i]) bad++;
      chk("mem_all", bad, 0);
      chk("bus_protocol", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
